// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply / divide unit.
//   Multiply uses a radix-4 Booth recoder (WIDTH/2 iterations).
//   Divide uses a restoring divider on operand magnitudes (WIDTH iterations).
//   The quotient truncates toward zero and the remainder is discarded.
//
// Ports:
//   clk             rising-edge clock
//   clr             synchronous active-high reset
//   data_operandA   multiplicand / dividend, sampled on the start cycle
//   data_operandB   multiplier / divisor, sampled on the start cycle
//   ctrl_MULT       start-multiply pulse (wins if ctrl_DIV is also high)
//   ctrl_DIV        start-divide pulse
//   data_result     product low word or quotient, held between results
//   data_exception  multiply overflow, divide overflow or divide-by-zero
//   data_resultRDY  one-cycle pulse while the result is first presented
//
// Optional build macro:
//   MULTDIV_FAST_DIV0_EN  when defined, a divide by zero skips the
//                         iterations and presents its result in cycle 1.
//
// A start pulse in any state aborts the current operation; WIDTH must be
// even and at least 4.
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_MUL = CW'(WIDTH / 2 - 1);
   localparam logic [CW-1:0] LAST_DIV = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // hi: Booth partial product (two guard bits so that +/-2M cannot overflow)
   //     or the partial remainder while dividing.
   // lo: multiplier bits shifting out / product low bits shifting in,
   //     or dividend bits shifting out / quotient bits shifting in.
   logic [WIDTH+1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             booth_q, booth_d;   // Booth bit to the right of lo[0]
   logic [WIDTH-1:0] m_q, m_d;           // multiplicand or divisor magnitude
   logic             neg_q, neg_d;       // quotient must be negated
   logic             div0_q, div0_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;

   logic [WIDTH+1:0]   m_x1, m_x2, addend, sum;
   logic [WIDTH+1:0]   mul_hi, rem_shift, diff, div_hi;
   logic [WIDTH-1:0]   mul_lo, div_lo, a_mag, b_mag;
   logic [2*WIDTH-1:0] prod;
   logic               mul_ovf;

   // One Booth iteration and one restoring-divide iteration, both computed
   // from the current registers; the FSM picks which one to commit.
   always_comb begin
      m_x1 = {{2{m_q[WIDTH-1]}}, m_q};
      m_x2 = {m_q[WIDTH-1], m_q, 1'b0};
      case ({lo_q[1:0], booth_q})
         3'b001, 3'b010: addend = m_x1;
         3'b011:         addend = m_x2;
         3'b100:         addend = -m_x2;
         3'b101, 3'b110: addend = -m_x1;
         default:        addend = '0;
      endcase
      sum    = hi_q + addend;
      mul_hi = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
      mul_lo = {sum[1:0], lo_q[WIDTH-1:2]};
      prod   = {mul_hi[WIDTH-1:0], mul_lo};
      // Signed overflow: the upper WIDTH+1 product bits are not all equal.
      mul_ovf = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));

      rem_shift = {hi_q[WIDTH:0], lo_q[WIDTH-1]};
      diff      = rem_shift - {2'b00, m_q};
      div_hi    = diff[WIDTH+1] ? rem_shift : diff;
      div_lo    = {lo_q[WIDTH-2:0], ~diff[WIDTH+1]};

      // Magnitude of the most negative value wraps to itself, which is the
      // correct unsigned magnitude.
      a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      booth_d  = booth_q;
      m_d      = m_q;
      neg_d    = neg_q;
      div0_d   = div0_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      exc_d    = exc_q;

      if (ctrl_MULT) begin
         state_d = S_MUL;
         cnt_d   = '0;
         hi_d    = '0;
         lo_d    = data_operandB;
         booth_d = 1'b0;
         m_d     = data_operandA;
      end else if (ctrl_DIV) begin
         state_d = S_DIV;
         cnt_d   = '0;
         hi_d    = '0;
         lo_d    = a_mag;
         booth_d = 1'b0;
         m_d     = b_mag;
         neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         div0_d  = (data_operandB == '0);
         ovf_d   = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
`ifdef MULTDIV_FAST_DIV0_EN
         if (data_operandB == '0) begin
            state_d  = S_DONE;
            result_d = '0;
            exc_d    = 1'b1;
         end
`endif
      end else begin
         case (state_q)
            S_MUL: begin
               hi_d    = mul_hi;
               lo_d    = mul_lo;
               booth_d = lo_q[1];
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == LAST_MUL) begin
                  state_d  = S_DONE;
                  result_d = prod[WIDTH-1:0];
                  exc_d    = mul_ovf;
               end
            end
            S_DIV: begin
               hi_d  = div_hi;
               lo_d  = div_lo;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_DIV) begin
                  state_d  = S_DONE;
                  result_d = div0_q ? '0 : (neg_q ? -div_lo : div_lo);
                  exc_d    = div0_q | ovf_q;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         booth_q  <= 1'b0;
         m_q      <= '0;
         neg_q    <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         booth_q  <= booth_d;
         m_q      <= m_d;
         neg_q    <= neg_d;
         div0_q   <= div0_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == S_DONE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed testbench for multdiv_unit (WIDTH = 32). Inputs are driven on the
// falling edge or just after the rising edge; outputs are sampled on the
// falling edge. Cycle numbers count from the start-pulse cycle (cycle 0).
module tb_multdiv_unit;

   logic        clk;
   logic        clr;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int checks;
   int errors;
   int first_rdy;
   int rdy_count;
   int exp_div0_cycle;

   multdiv_unit #(.WIDTH(32)) dut (
      .clk            (clk),
      .clr            (clr),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents a start pulse for one cycle (cycle 0), then scrambles the
   // operands, returning just after the edge that ends cycle 0.
   task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clk);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Watches the next n cycles; reports the first cycle with RDY (-1 if none)
   // and how many cycles had RDY high.
   task automatic observe(input int n, output int first, output int count);
      first = -1;
      count = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (data_resultRDY === 1'b1) begin
            count++;
            if (first < 0) first = i;
         end
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      clr           = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
`ifdef MULTDIV_FAST_DIV0_EN
      exp_div0_cycle = 1;
`else
      exp_div0_cycle = 33;
`endif

      // Reset
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      observe(5, first_rdy, rdy_count);
      check("reset_rdy_count", rdy_count, 0);
      check("reset_result", data_result, 32'h0);
      check("reset_exc", {31'b0, data_exception}, 32'h0);
      $display("reset: result=%h exc=%b rdy_count=%0d", data_result, data_exception, rdy_count);

      // Multiply 7 * -3 = -21
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      observe(20, first_rdy, rdy_count);
      check("mul1_rdy_cycle", first_rdy, 17);
      check("mul1_rdy_count", rdy_count, 1);
      check("mul1_result", data_result, 32'hFFFF_FFEB);
      check("mul1_exc", {31'b0, data_exception}, 32'h0);
      $display("mul 7*-3: rdy@%0d result=%h exc=%b", first_rdy, data_result, data_exception);

      // Multiply 2^16 * 2^16 = 2^32 -> overflow, low word 0
      start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
      observe(20, first_rdy, rdy_count);
      check("mul2_rdy_cycle", first_rdy, 17);
      check("mul2_rdy_count", rdy_count, 1);
      check("mul2_result", data_result, 32'h0);
      check("mul2_exc", {31'b0, data_exception}, 32'h1);
      $display("mul 2^16*2^16: rdy@%0d result=%h exc=%b", first_rdy, data_result, data_exception);

      // Divide -100 / 7 = -14 (truncation toward zero) = 0xFFFFFFF2
      start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
      observe(36, first_rdy, rdy_count);
      check("div1_rdy_cycle", first_rdy, 33);
      check("div1_rdy_count", rdy_count, 1);
      check("div1_result", data_result, 32'hFFFF_FFF2);
      check("div1_exc", {31'b0, data_exception}, 32'h0);
      $display("div -100/7: rdy@%0d result=%h exc=%b", first_rdy, data_result, data_exception);

      // Divide overflow: min / -1
      start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      observe(36, first_rdy, rdy_count);
      check("divovf_rdy_cycle", first_rdy, 33);
      check("divovf_rdy_count", rdy_count, 1);
      check("divovf_result", data_result, 32'h8000_0000);
      check("divovf_exc", {31'b0, data_exception}, 32'h1);
      $display("div min/-1: rdy@%0d result=%h exc=%b", first_rdy, data_result, data_exception);

      // Divide by zero
      start_op(1'b0, 1'b1, 32'd5, 32'd0);
      observe(36, first_rdy, rdy_count);
      check("div0_rdy_cycle", first_rdy, exp_div0_cycle);
      check("div0_rdy_count", rdy_count, 1);
      check("div0_result", data_result, 32'h0);
      check("div0_exc", {31'b0, data_exception}, 32'h1);
      $display("div 5/0: rdy@%0d result=%h exc=%b", first_rdy, data_result, data_exception);

      // Abort: multiply 2*3, then divide 9/2 started in cycle 5
      start_op(1'b1, 1'b0, 32'd2, 32'd3);
      observe(4, first_rdy, rdy_count);
      check("abort_pre_rdy_count", rdy_count, 0);
      start_op(1'b0, 1'b1, 32'd9, 32'd2);
      observe(40, first_rdy, rdy_count);
      check("abort_rdy_cycle", first_rdy, 33);
      check("abort_rdy_count", rdy_count, 1);
      check("abort_result", data_result, 32'd4);
      check("abort_exc", {31'b0, data_exception}, 32'h0);
      $display("abort mul->div 9/2: rdy@%0d count=%0d result=%h", first_rdy, rdy_count, data_result);

      // clr in cycle 10 of a multiply
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      observe(9, first_rdy, rdy_count);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      observe(20, first_rdy, rdy_count);
      check("clr_rdy_count", rdy_count, 0);
      check("clr_result", data_result, 32'h0);
      check("clr_exc", {31'b0, data_exception}, 32'h0);
      $display("clr mid-mul: rdy_count=%0d result=%h exc=%b", rdy_count, data_result, data_exception);

      // Both starts high: multiply wins, 6*3 = 18
      start_op(1'b1, 1'b1, 32'd6, 32'd3);
      observe(20, first_rdy, rdy_count);
      check("both_rdy_cycle", first_rdy, 17);
      check("both_rdy_count", rdy_count, 1);
      check("both_result", data_result, 32'd18);
      check("both_exc", {31'b0, data_exception}, 32'h0);
      $display("mul+div 6,3: rdy@%0d result=%h exc=%b", first_rdy, data_result, data_exception);

      // Hold for 20 idle cycles while operands toggle
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold_result", data_result, 32'd18);
         check("hold_exc", {31'b0, data_exception}, 32'h0);
         check("hold_rdy", {31'b0, data_resultRDY}, 32'h0);
         data_operandA = $urandom;
         data_operandB = $urandom;
      end
      $display("hold 20 cycles: result=%h exc=%b", data_result, data_exception);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
